// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: PC register feedback, instruction memory handshake,
// IF/ID register and redirect inputs.
interface fetch_unit_if;
    logic [31:0] pc;
    logic [31:0] target;
    logic        pc_load;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        halted;

    modport master (
        input  pc, imem_ack, imem_rdata, id_stall, redirect_valid, redirect_target,
        output target, pc_load, imem_req, imem_addr,
               if_id_valid, if_id_instr, if_id_pc, halted
    );

    modport slave (
        output pc, imem_ack, imem_rdata, id_stall, redirect_valid, redirect_target,
        input  target, pc_load, imem_req, imem_addr,
               if_id_valid, if_id_instr, if_id_pc, halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives imem from the current PC, fills the IF/ID
// register, and feeds the next PC (sequential or redirect) back to the PC register.
module fetch_unit #(
    parameter logic [31:0] PC_INC    = 32'd4,
    parameter logic [31:0] HALT_ADDR = 32'h0000007C,
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALTED} state_t;

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        redir;

    // Redirect is dead in HALTED and must not leak onto pc_load while in reset.
    assign redir = bus.redirect_valid && !reset && (state_q != HALTED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            ifpc_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            ifpc_q       <= ifpc_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   state_d = FETCH;
            FETCH: begin
                if (redir)
                    state_d = FETCH;
                else if (bus.imem_ack)
                    state_d = (bus.pc == HALT_ADDR) ? HALTED
                            : (bus.id_stall ? HOLD : FETCH);
            end
            HOLD: begin
                if (redir || !bus.id_stall)
                    state_d = FETCH;
            end
            HALTED: state_d = HALTED;
        endcase
    end

    always_comb begin
        bus.imem_req   = 1'b0;
        bus.imem_addr  = bus.pc;
        bus.pc_load    = 1'b0;
        bus.target     = '0;
        valid_d        = valid_q;
        instr_d        = instr_q;
        ifpc_d         = ifpc_q;
        hold_valid_d   = hold_valid_q;
        hold_instr_d   = hold_instr_q;
        hold_pc_d      = hold_pc_q;

        if (state_q == FETCH)
            bus.imem_req = 1'b1;

        if (redir) begin
            bus.pc_load  = 1'b1;
            bus.target   = bus.redirect_target;
            valid_d      = 1'b0;
            instr_d      = NOP_INSTR;
            hold_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                FETCH: begin
                    if (bus.imem_ack && !bus.id_stall) begin
                        valid_d = 1'b1;
                        instr_d = bus.imem_rdata;
                        ifpc_d  = bus.pc;
                        if (bus.pc != HALT_ADDR) begin
                            bus.pc_load = 1'b1;
                            bus.target  = bus.pc + PC_INC;
                        end
                    end else if (bus.imem_ack) begin
                        hold_valid_d = 1'b1;
                        hold_instr_d = bus.imem_rdata;
                        hold_pc_d    = bus.pc;
                    end else if (!bus.id_stall) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (!bus.id_stall) begin
                        valid_d      = 1'b1;
                        instr_d      = hold_instr_q;
                        ifpc_d       = hold_pc_q;
                        hold_valid_d = 1'b0;
                        bus.pc_load  = 1'b1;
                        bus.target   = hold_pc_q + PC_INC;
                    end
                end
                HALTED: begin
                    // A halt instruction captured under stall is still owed to ID.
                    if (!bus.id_stall) begin
                        if (hold_valid_q) begin
                            valid_d      = 1'b1;
                            instr_d      = hold_instr_q;
                            ifpc_d       = hold_pc_q;
                            hold_valid_d = 1'b0;
                        end else begin
                            valid_d = 1'b0;
                            instr_d = NOP_INSTR;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.if_id_valid = valid_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc    = ifpc_q;
    assign bus.halted      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch scenarios push expected
// deliveries; a negedge monitor checks each instruction ID accepts.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    fetch_unit_if bus();

    fetch_unit #(
        .PC_INC    (32'd4),
        .HALT_ADDR (32'h0000007C),
        .NOP_INSTR (32'h00000000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // PC register and instruction memory around the fetch stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bus.pc <= '0;
        else if (bus.pc_load)
            bus.pc <= bus.target;
    end

    always_comb begin
        bus.imem_rdata = bus.imem_ack ? mem_word(bus.imem_addr) : 32'hDEADBEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_q.push_back({a, mem_word(a)});
    endtask

    task automatic step(input logic ack, input logic stall, input logic redir,
                        input logic [31:0] rt);
        @(posedge clk);
        #1;
        bus.imem_ack        = ack;
        bus.id_stall        = stall;
        bus.redirect_valid  = redir;
        bus.redirect_target = rt;
        #1;
    endtask

    // Releases reset, checks the IDLE cycle and the first fetch at address 0.
    task automatic start_seq(input bit deliver0);
        @(posedge clk);
        #1;
        reset               = 1'b0;
        bus.imem_ack        = 1'b1;
        bus.id_stall        = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        #1;
        chk("idle_req", bus.imem_req, 0);
        chk("idle_pc_load", bus.pc_load, 0);
        step(1, 0, 0, 0);
        chk("c1_req", bus.imem_req, 1);
        chk("c1_addr", bus.imem_addr, 32'h0);
        chk("c1_pc_load", bus.pc_load, 1);
        chk("c1_target", bus.target, 32'h4);
        if (deliver0) push_exp(32'h0);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.if_id_valid && !bus.id_stall) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_delivery: got pc %h expected none", bus.if_id_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("deliver_pc", bus.if_id_pc, e.pc);
                chk("deliver_instr", bus.if_id_instr, e.instr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset               = 1'b1;
        bus.imem_ack        = 1'b1;
        bus.id_stall        = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst_valid", bus.if_id_valid, 0);
        chk("rst_instr", bus.if_id_instr, 32'h0);
        chk("rst_ifpc", bus.if_id_pc, 32'h0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_req", bus.imem_req, 0);
        chk("rst_pc_load", bus.pc_load, 0);
        chk("rst_target", bus.target, 32'h0);

        // Startup at zero-wait memory
        start_seq(1);
        step(1, 0, 0, 0);
        chk("c2_valid", bus.if_id_valid, 1);
        chk("c2_ifpc", bus.if_id_pc, 32'h0);
        chk("c2_target", bus.target, 32'h8);
        push_exp(32'h4);
        step(1, 0, 0, 0); push_exp(32'h8);
        step(1, 0, 0, 0); push_exp(32'hC);

        // Wait states: ack every third cycle
        for (int k = 0; k < 2; k++) begin
            logic [31:0] a;
            a = 32'h10 + 32'(4 * k);
            step(0, 0, 0, 0);
            chk("ws_req", bus.imem_req, 1);
            chk("ws_addr", bus.imem_addr, a);
            chk("ws_noack_pc_load", bus.pc_load, 0);
            step(0, 0, 0, 0);
            chk("ws_noack_pc_load", bus.pc_load, 0);
            chk("ws_bubble_valid", bus.if_id_valid, 0);
            chk("ws_bubble_instr", bus.if_id_instr, 32'h0);
            step(1, 0, 0, 0);
            chk("ws_ack_pc_load", bus.pc_load, 1);
            chk("ws_ack_target", bus.target, a + 32'h4);
            push_exp(a);
        end
        step(1, 0, 0, 0); push_exp(32'h18);
        step(1, 0, 0, 0); push_exp(32'h1C);

        // Stall with ack at 0x20
        step(1, 1, 0, 0);
        chk("st_addr", bus.imem_addr, 32'h20);
        chk("st_pc_load", bus.pc_load, 0);
        push_exp(32'h20);
        for (int k = 0; k < 2; k++) begin
            step(1, 1, 0, 0);
            chk("hold_req", bus.imem_req, 0);
            chk("hold_pc_load", bus.pc_load, 0);
            chk("hold_ifpc", bus.if_id_pc, 32'h1C);
            chk("hold_valid", bus.if_id_valid, 1);
        end
        step(1, 0, 0, 0);
        chk("rel_pc_load", bus.pc_load, 1);
        chk("rel_target", bus.target, 32'h24);
        step(1, 0, 0, 0);
        chk("rel_ifpc", bus.if_id_pc, 32'h20);
        chk("rel_req", bus.imem_req, 1);
        chk("rel_addr", bus.imem_addr, 32'h24);
        push_exp(32'h24);
        step(1, 0, 0, 0); push_exp(32'h28);
        step(1, 0, 0, 0);  // 0x2C is flushed below while stalled

        // Redirect at 0x30 with ack and stall
        step(1, 1, 1, 32'h40);
        chk("rd_addr", bus.imem_addr, 32'h30);
        chk("rd_pc_load", bus.pc_load, 1);
        chk("rd_target", bus.target, 32'h40);
        step(1, 0, 0, 0);
        chk("rd_flush_valid", bus.if_id_valid, 0);
        chk("rd_next_addr", bus.imem_addr, 32'h40);
        chk("rd_next_target", bus.target, 32'h44);
        push_exp(32'h40);
        for (int a = 32'h44; a <= 32'h78; a += 4) begin
            step(1, 0, 0, 0);
            push_exp(32'(a));
        end

        // Halt at 0x7C
        step(1, 0, 0, 0);
        chk("h_addr", bus.imem_addr, 32'h7C);
        chk("h_pc_load", bus.pc_load, 0);
        chk("h_halted_pre", bus.halted, 0);
        push_exp(32'h7C);
        step(1, 0, 0, 0);
        chk("h_halted", bus.halted, 1);
        chk("h_req", bus.imem_req, 0);
        chk("h_pc_load2", bus.pc_load, 0);
        chk("h_ifpc", bus.if_id_pc, 32'h7C);
        chk("h_valid", bus.if_id_valid, 1);
        step(1, 0, 1, 32'h0);
        chk("h_bubble", bus.if_id_valid, 0);
        chk("h_redir_pc_load", bus.pc_load, 0);
        chk("h_redir_halted", bus.halted, 1);
        step(1, 0, 0, 0);
        chk("h_after_halted", bus.halted, 1);
        chk("h_after_req", bus.imem_req, 0);
        chk("h_after_addr", bus.imem_addr, 32'h7C);

        // Reset out of HALTED, then async reset in the middle of HOLD
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rh_halted", bus.halted, 0);
        start_seq(0);
        step(1, 1, 0, 0);
        chk("e_stall_pc_load", bus.pc_load, 0);
        step(1, 1, 0, 0);
        chk("e_hold_req", bus.imem_req, 0);
        chk("e_hold_valid", bus.if_id_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", bus.if_id_valid, 0);
        chk("ar_halted", bus.halted, 0);
        chk("ar_req", bus.imem_req, 0);
        chk("ar_pc_load", bus.pc_load, 0);
        chk("ar_target", bus.target, 32'h0);
        start_seq(1);
        step(1, 0, 0, 0);
        chk("e_c2_ifpc", bus.if_id_pc, 32'h0);
        push_exp(32'h4);
        step(1, 0, 0, 0); push_exp(32'h8);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the PC register.
- Consumes the current `pc` and issues instruction-memory requests with a req/ack handshake.
- Loads the IF/ID pipeline register, and drives `pc_load`/`target` back into the PC register: sequential `pc+PC_INC`, or a branch/jump redirect from later stages.
- Handles ID back-pressure (stall), redirect flush, and a terminal halt address.

Parameters:
- PC_INC, 4, byte increment for sequential fetch.
- HALT_ADDR, 32'h0000007C, instruction address that terminates fetch.
- NOP_INSTR, 32'h00000000, value loaded into `if_id_instr` on bubble/flush/reset.

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- reset, input, 1, asynchronous active-high reset.
- pc, input, 32, current PC from the PC register.
- target, output, 32, next PC value presented to the PC register.
- pc_load, output, 1, PC register loads `target` on the next posedge when high.
- imem_req, output, 1, instruction memory request.
- imem_addr, output, 32, fetch address.
- imem_ack, input, 1, `imem_rdata` is valid for `imem_addr` this cycle.
- imem_rdata, input, 32, instruction word.
- id_stall, input, 1, decode cannot accept a new instruction this cycle.
- redirect_valid, input, 1, branch/jump taken; refetch from `redirect_target`.
- redirect_target, input, 32, redirect address.
- if_id_valid, output, 1, IF/ID register holds a live instruction.
- if_id_instr, output, 32, IF/ID instruction.
- if_id_pc, output, 32, address of `if_id_instr`.
- halted, output, 1, fetch has stopped at HALT_ADDR.

Behaviour:
- Reset (async, immediate) sets the following registered values:
  - state=IDLE, `if_id_valid`=0, `if_id_instr`=NOP_INSTR, `if_id_pc`=0, `halted`=0, hold buffer empty.
  - Combinational outputs resolve to `imem_req`=0, `pc_load`=0, `target`=0.
- Memory protocol: no outstanding transactions.
  - `imem_ack` qualifies `imem_rdata` only for the `imem_addr` of the same cycle.
  - Dropping or changing the request after any cycle is legal.
- States:
  - IDLE: exactly one cycle after reset deasserts, giving the PC register time to load its first address. No request. Always moves to FETCH.
  - FETCH: `imem_req`=1, `imem_addr`=`pc` (combinational).
    - ack && !id_stall: `if_id` loads {1, `imem_rdata`, `pc`}; `pc_load`=1, `target`=`pc`+PC_INC; stay in FETCH.
    - ack && id_stall: rdata/pc go into the hold buffer; `if_id` unchanged; `pc_load`=0; go to HOLD.
    - !ack && !id_stall: bubble: `if_id_valid`<=0, `if_id_instr`<=NOP_INSTR.
    - !ack && id_stall: `if_id` unchanged.
  - HOLD: `imem_req`=0.
    - While `id_stall`: `if_id` unchanged.
    - On !id_stall: the hold buffer moves into `if_id`; `pc_load`=1, `target`=hold_pc+PC_INC; go to FETCH.
  - HALTED: `imem_req`=0, `pc_load`=0, `halted`=1.
    - `if_id` keeps its final instruction until !id_stall, then becomes a bubble and stays one.
    - Only reset exits HALTED.
- Halt entry: any capture (into `if_id` or the hold buffer) whose pc==HALT_ADDR sends the FSM to HALTED instead of FETCH.
  - No `pc_load`, so the PC stays at HALT_ADDR.
  - A captured HALT_ADDR instruction is still delivered to ID.
- Redirect has priority over everything except reset and HALTED:
  - `pc_load`=1, `target`=`redirect_target`.
  - Any same-cycle ack is discarded and the hold buffer is cleared.
  - `if_id_valid`<=0, `if_id_instr`<=NOP_INSTR, even if `id_stall`=1.
  - Next state is FETCH (also from IDLE and HOLD).
  - Redirect in HALTED is ignored.
- Arithmetic: `pc`+PC_INC is 32-bit modulo; wrap from 32'hFFFFFFFC to 0 is silent.
- Throughput: one instruction per cycle with zero-wait memory and no stall; first `if_id_valid` appears 2 cycles after reset release.
- `pc_load` is never asserted in IDLE, in HALTED, or in FETCH without ack (except on redirect).

Test Plan:
- Startup: release reset, PC first_address 0, `imem_ack` tied 1, no stall.
  - `imem_req` is low in cycle 0.
  - Cycle 1: `imem_addr`=0, `pc_load`=1, `target`=4.
  - Cycle 2: `if_id_pc`=0, `if_id_valid`=1.
  - Then `if_id_pc` steps 4, 8, 12 on consecutive cycles.
- Wait states: ack asserted every 3rd cycle at `pc`=0x10.
  - Bubbles (`if_id_valid`=0, instr=0) appear on the non-ack cycles.
  - `pc_load` pulses only with ack.
  - `if_id_pc` sequence is 0x10, 0x14.
- Stall/hold: ack at `pc`=0x20 while `id_stall`=1 for 3 cycles.
  - FSM enters HOLD, `imem_req`=0, `if_id` unchanged.
  - On stall release: `if_id_pc`=0x20, `target`=0x24, `pc_load`=1.
- Redirect: redirect_valid with target 0x40, simultaneously with ack and `id_stall`=1 at `pc`=0x30.
  - `pc_load`=1, `target`=0x40.
  - `if_id_valid`=0 next cycle; no 0x30 instruction is ever delivered.
  - Next fetch is at `imem_addr`=0x40.
- Halt: sequential fetch reaches 0x7C.
  - The 0x7C instruction is delivered; `halted`=1 afterward.
  - `imem_req` and `pc_load` stay 0.
  - A later redirect_valid to 0x00 is ignored; only reset restarts.
- Async reset mid-HOLD: assert reset between clock edges.
  - Outputs clear immediately: `if_id_valid`=0, `halted`=0, `imem_req`=0.
  - After release, the startup sequence repeats from IDLE.
